// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Each line holds a valid bit, a tag and a four-word block. A read miss holds
// the block read for MEM_LATENCY cycles, then fills the line; the still-pending
// read hits on the following cycle.
// Optional feature: define CACHE_STATS_EN to add saturating hit/miss counters.

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module cache_controller #(
   parameter int NUM_SETS    = 1024,
   parameter int MEM_LATENCY = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [`ADDRESS_LEN-1:0]  cpu_address,
   input  logic                     cpu_read,
   input  logic                     cpu_write,
   input  logic [`WORD_LEN-1:0]     cpu_write_data,
   output logic [`WORD_LEN-1:0]     cpu_read_data,
   output logic                     cpu_ready,
   output logic [`ADDRESS_LEN-1:0]  mem_address,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [`WORD_LEN-1:0]     mem_write_data,
   input  logic [4*`WORD_LEN-1:0]   mem_read_data
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count
`endif
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = `ADDRESS_LEN - 2 - IDX_W;
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

   logic [0:0]           state;
   logic [CNT_W-1:0]     count;
   logic [NUM_SETS-1:0]  valid;
   logic [TAG_W-1:0]     tags  [NUM_SETS];
   logic [`WORD_LEN-1:0] words [NUM_SETS][4];
   logic [TAG_W-1:0]     fill_tag;
   logic [IDX_W-1:0]     fill_index;

   logic [1:0]           offset;
   logic [IDX_W-1:0]     index;
   logic [TAG_W-1:0]     tag;
   logic                 hit;
   logic                 rd_hit;
   logic                 rd_miss;
   logic                 wr_hit;
   logic                 fill_done;

   assign offset    = cpu_address[1:0];
   assign index     = cpu_address[IDX_W+1:2];
   assign tag       = cpu_address[`ADDRESS_LEN-1:IDX_W+2];
   assign hit       = valid[index] && (tags[index] == tag);
   assign rd_hit    = (state == IDLE) && !cpu_write && cpu_read && hit;
   assign rd_miss   = (state == IDLE) && !cpu_write && cpu_read && !hit;
   assign wr_hit    = (state == IDLE) && cpu_write && hit;
   // Reset forces state to IDLE asynchronously, so an interrupted fill never completes.
   assign fill_done = (state == FILL) && (count == '0);

   // Control state: FSM, latency counter, latched fill address and valid bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         count      <= '0;
         valid      <= '0;
         fill_tag   <= '0;
         fill_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_miss) begin
                  state      <= FILL;
                  count      <= CNT_W'(MEM_LATENCY - 1);
                  fill_tag   <= tag;
                  fill_index <= index;
               end
            end
            default: begin
               if (count == '0) begin
                  valid[fill_index] <= 1'b1;
                  state             <= IDLE;
               end else begin
                  count <= count - 1'b1;
               end
            end
         endcase
      end
   end

   // Line storage: block fill from memory, or single-word update on a write hit.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tags[fill_index] <= fill_tag;
         for (int w = 0; w < 4; w++) begin
            words[fill_index][w] <= mem_read_data[w*`WORD_LEN +: `WORD_LEN];
         end
      end else if (wr_hit) begin
         words[index][offset] <= cpu_write_data;
      end
   end

   // Output decode; everything is held at zero while reset is asserted.
   always_comb begin
      cpu_ready      = 1'b0;
      cpu_read_data  = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      if (rst) begin
         if (state == IDLE) begin
            if (cpu_write) begin
               mem_write      = 1'b1;
               mem_address    = cpu_address;
               mem_write_data = cpu_write_data;
               cpu_ready      = 1'b1;
            end else if (rd_hit) begin
               cpu_ready     = 1'b1;
               cpu_read_data = words[index][offset];
            end
         end else begin
            mem_read    = 1'b1;
            mem_address = {fill_tag, fill_index, 2'b00};
         end
      end
   end

`ifdef CACHE_STATS_EN
   // Saturating read hit/miss counters, bumped at IDLE detection only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (rd_hit && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (rd_miss && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule
